// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: common baud divisors (clk cycles per bit), the
// transmitter state encoding and the frame data width.
// No ports.
// ---------------------------------------------------------------------------
package uart_pkg;

    // Clock cycles per bit for common clock/baud combinations.
    localparam logic [12:0] BPS_50MHZ_9600   = 13'd5208;
    localparam logic [12:0] BPS_50MHZ_115200 = 13'd434;
    localparam logic [12:0] BPS_12MHZ_9600   = 13'd1250;
    localparam logic [12:0] BPS_12MHZ_115200 = 13'd104;

    // Data bits per 8N1 frame.
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } tx_state_t;

endpackage

// File: rtl/uart_bps_counter.sv
// ---------------------------------------------------------------------------
// uart_bps_counter
// Bit-time divider. While run is high it counts 0..BPS-1 and wraps; bit_tick
// marks the last cycle of each bit time. While run is low the count is held
// at zero, so every run period starts on a fresh bit boundary.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   run      in   count enable; low clears the count
//   bit_tick out  one-cycle pulse on the final cycle of a bit time
// ---------------------------------------------------------------------------
module uart_bps_counter
    import uart_pkg::*;
#(
    parameter logic [12:0] BPS = BPS_50MHZ_115200
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_tick
);

    logic [12:0] count;

    assign bit_tick = run && (count == BPS - 13'd1);

    // NOTE: state in always_ff is updated with <= so every register samples
    // the pre-edge values of the others; = here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            count <= '0;
        end else if (bit_tick) begin
            count <= '0;
        end else begin
            count <= count + 13'd1;
        end
    end

endmodule

// File: rtl/uart_tx_module.sv
// ---------------------------------------------------------------------------
// uart_tx_module
// 8N1 UART transmitter: start bit, 8 data bits LSB first, one stop bit, each
// held BPS clk cycles, followed by a single DONE cycle that pulses tx_done.
// A request is accepted only in IDLE, so a controller that still holds
// tx_en_sig while tx_done is high cannot retrigger a frame from DONE.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset; aborts any frame
//   tx_en_sig  in   transmit request, level-sensitive, sampled in IDLE only
//   tx_data    in   [7:0] byte, captured on the accepting edge
//   tx_done    out  one-cycle pulse after the stop bit completes
//   tx_pin     out  registered serial line, idles high
// ---------------------------------------------------------------------------
module uart_tx_module
    import uart_pkg::*;
#(
    parameter logic [12:0] BPS = BPS_50MHZ_115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en_sig,
    input  logic [7:0] tx_data,
    output logic       tx_done,
    output logic       tx_pin
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t  state;
    tx_state_t  next_state;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic       bit_tick;
    logic       baud_run;
    logic       next_pin;

    // The divider only runs while a bit is on the line; holding it cleared in
    // IDLE and DONE means the start bit always gets a full BPS cycles.
    assign baud_run = (state == START) || (state == DATA) || (state == STOP);

    uart_bps_counter #(
        .BPS (BPS)
    ) u_bps_counter (
        .clk      (clk),
        .rst      (rst),
        .run      (baud_run),
        .bit_tick (bit_tick)
    );

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (tx_en_sig) next_state = START;
            START:   if (bit_tick)  next_state = DATA;
            DATA:    if (bit_tick && bit_cnt == LAST_BIT) next_state = STOP;
            STOP:    if (bit_tick)  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // tx_pin is registered, so it is computed from the state being entered.
    // Inside DATA the shift happens on the same edge as the bit change, so
    // the bit about to appear is shift_reg[1], not shift_reg[0].
    always_comb begin
        next_pin = 1'b1;
        case (next_state)
            START: next_pin = 1'b0;
            DATA: begin
                if (state == DATA && bit_tick) next_pin = shift_reg[1];
                else                           next_pin = shift_reg[0];
            end
            default: next_pin = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx_pin    <= 1'b1;
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            state  <= next_state;
            tx_pin <= next_pin;

            if (state == IDLE && tx_en_sig) begin
                shift_reg <= tx_data;
            end else if (state == DATA && bit_tick) begin
                shift_reg <= shift_reg >> 1;
            end

            // Wraps 7 -> 0 naturally on the last data bit.
            if (state == DATA) begin
                if (bit_tick) bit_cnt <= bit_cnt + 3'd1;
            end else begin
                bit_cnt <= '0;
            end
        end
    end

    assign tx_done = (state == DONE);

endmodule

// File: tb/tb_uart_tx_module.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_module
// Three transmitters (BPS = 4, 434, 2) driven by one directed sequence.
// Expected bytes are queued when a request is issued and popped when a frame
// is decoded from tx_pin. All sampling happens on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_module;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, done_a, pin_a;
    logic [7:0] data_a;
    logic       rst_b, en_b, done_b, pin_b;
    logic [7:0] data_b;
    logic       rst_c, en_c, done_c, pin_c;
    logic [7:0] data_c;

    uart_tx_module #(.BPS(13'd4)) dut_a (
        .clk(clk), .rst(rst_a), .tx_en_sig(en_a), .tx_data(data_a),
        .tx_done(done_a), .tx_pin(pin_a)
    );
    uart_tx_module #(.BPS(13'd434)) dut_b (
        .clk(clk), .rst(rst_b), .tx_en_sig(en_b), .tx_data(data_b),
        .tx_done(done_b), .tx_pin(pin_b)
    );
    uart_tx_module #(.BPS(13'd2)) dut_c (
        .clk(clk), .rst(rst_c), .tx_en_sig(en_c), .tx_data(data_c),
        .tx_done(done_c), .tx_pin(pin_c)
    );

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [7:0] exp_q[$];

    int   done_cnt  [3] = '{0, 0, 0};
    logic prev_done [3] = '{1'b0, 1'b0, 1'b0};
    logic done_twice[3] = '{1'b0, 1'b0, 1'b0};
    logic done_low  [3] = '{1'b0, 1'b0, 1'b0};

    function automatic logic get_pin(input int sel);
        case (sel)
            0:       return pin_a;
            1:       return pin_b;
            default: return pin_c;
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    task automatic set_en(input int sel, input logic v);
        case (sel)
            0:       en_a = v;
            1:       en_b = v;
            default: en_c = v;
        endcase
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Protocol watch: tx_done pulse count, no back-to-back highs, never low pin.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (get_done(i) === 1'b1) begin
                done_cnt[i] <= done_cnt[i] + 1;
                if (prev_done[i] === 1'b1) done_twice[i] <= 1'b1;
                if (get_pin(i) === 1'b0)   done_low[i]   <= 1'b1;
            end
            prev_done[i] <= get_done(i);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_and_check(input string tag, input logic [7:0] got);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            check(tag, got, exp_q.pop_front());
        end
    endtask

    // Waits (bounded) for a start bit on instance sel, decodes one frame at
    // mid-bit points, checks the DONE cycle and scores the byte. Returns at
    // the falling edge inside the DONE cycle. disturb_j (instance 0 only)
    // changes tx_data and drops tx_en_sig that many cycles into the frame.
    task automatic recv_frame(input int sel, input int bps, input bit drop_on_done,
                              input int disturb_j, input string tag,
                              output int start_cyc, output int done_cyc);
        logic [7:0] got;
        int         w;
        got       = '0;
        start_cyc = -1;
        done_cyc  = -1;
        w         = 0;
        while (get_pin(sel) !== 1'b0 && w < 20 * bps + 50) begin
            @(negedge clk);
            w++;
        end
        if (get_pin(sel) !== 1'b0) begin
            check({tag, "_start_timeout"}, 32'd1, 32'd0);
            return;
        end
        start_cyc = cyc;
        for (int j = 1; j <= 10 * bps; j++) begin
            @(negedge clk);
            if (j == bps / 2)
                check({tag, "_start_bit"}, get_pin(sel), 1'b0);
            if (j >= bps && j < 9 * bps && (j - bps) % bps == bps / 2)
                got[(j - bps) / bps] = get_pin(sel);
            if (j == 9 * bps + bps / 2)
                check({tag, "_stop_bit"}, get_pin(sel), 1'b1);
            if (j == 10 * bps - 1)
                check({tag, "_done_early"}, get_done(sel), 1'b0);
            if (sel == 0 && j == disturb_j) begin
                data_a = 8'hFF;
                en_a   = 1'b0;
            end
        end
        check({tag, "_done_pulse"}, get_done(sel), 1'b1);
        check({tag, "_done_pin"}, get_pin(sel), 1'b1);
        done_cyc = cyc;
        if (drop_on_done) set_en(sel, 1'b0);
        pop_and_check({tag, "_byte"}, got);
    endtask

    initial begin
        logic [9:0] pat;
        logic [7:0] got;
        int         bad;
        int         s, d, prev_d, d0;
        logic [7:0] hs_bytes[3];

        // ---------------- reset held with a pending request ----------------
        rst_a = 1'b1; en_a = 1'b1; data_a = 8'h2E;
        rst_b = 1'b1; en_b = 1'b0; data_b = 8'h00;
        rst_c = 1'b1; en_c = 1'b0; data_c = 8'h00;
        @(negedge clk);
        check("reset_pin", pin_a, 1'b1);
        check("reset_done", done_a, 1'b0);
        bad = 0;
        for (int k = 0; k < 49; k++) begin
            @(negedge clk);
            if (pin_a !== 1'b1 || done_a !== 1'b0) bad++;
        end
        check("reset_hold_idle", bad, 0);

        // ---------------- single byte 2E, cycle-exact waveform -------------
        pat = 10'b1001011100;   // slot 0 = start ... slot 9 = stop
        got = '0;
        exp_q.push_back(8'h2E);
        rst_a = 1'b0;           // next edge accepts the still-pending request
        for (int k = 1; k <= 42; k++) begin
            @(negedge clk);
            if (k == 1) en_a = 1'b0;
            if (k <= 40) begin
                check($sformatf("single_pin_k%0d", k), pin_a, pat[(k - 1) / 4]);
                check($sformatf("single_done_k%0d", k), done_a, 1'b0);
            end
            if (k > 4 && k <= 36 && (k - 1) % 4 == 2) got[(k - 5) / 4] = pin_a;
            if (k == 41) begin
                check("single_done_c41", done_a, 1'b1);
                check("single_pin_c41", pin_a, 1'b1);
            end
            if (k == 42) check("single_done_c42", done_a, 1'b0);
        end
        pop_and_check("single_byte", got);

        // ---------------- mid-frame data change and request drop -----------
        repeat (3) @(negedge clk);
        data_a = 8'h2E;
        en_a   = 1'b1;
        exp_q.push_back(8'h2E);
        recv_frame(0, 4, 1'b0, 14, "midchg", s, d);

        // ---------------- reset during data bit 3 --------------------------
        repeat (3) @(negedge clk);
        data_a = 8'h00;
        en_a   = 1'b1;
        bad    = 0;
        while (pin_a !== 1'b0 && bad < 20) begin
            @(negedge clk);
            bad++;
        end
        check("abort_started", pin_a, 1'b0);
        en_a = 1'b0;
        for (int j = 1; j <= 17; j++) @(negedge clk);   // inside bit 3
        check("abort_pre_pin", pin_a, 1'b0);
        d0    = done_cnt[0];
        rst_a = 1'b1;
        @(negedge clk);
        check("abort_pin", pin_a, 1'b1);
        check("abort_done", done_a, 1'b0);
        rst_a = 1'b0;
        bad   = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (pin_a !== 1'b1) bad++;
        end
        check("abort_line_idle", bad, 0);
        check("abort_no_done", done_cnt[0], d0);
        data_a = 8'hA5;
        en_a   = 1'b1;
        exp_q.push_back(8'hA5);
        recv_frame(0, 4, 1'b1, -1, "after_abort", s, d);

        // ---------------- three-byte handshake at BPS 434 ------------------
        hs_bytes = '{8'h2E, 8'h3F, 8'hDD};
        rst_b = 1'b0;
        @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            data_b = hs_bytes[f];
            en_b   = 1'b1;
            exp_q.push_back(hs_bytes[f]);
            recv_frame(1, 434, 1'b1, -1, $sformatf("hs%0d", f), s, d);
            repeat (3) @(negedge clk);
        end
        bad = 0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (pin_b !== 1'b1) bad++;
        end
        check("hs_no_fourth_frame", bad, 0);
        check("hs_done_count", done_cnt[1], 3);

        // ---------------- continuous request at BPS 2 ----------------------
        data_c = 8'h55;
        en_c   = 1'b1;
        rst_c  = 1'b0;
        prev_d = 0;
        for (int f = 0; f < 3; f++) begin
            exp_q.push_back(8'h55);
            recv_frame(2, 2, (f == 2), -1, $sformatf("cont%0d", f), s, d);
            if (f > 0) check($sformatf("cont_gap%0d", f), s - prev_d, 2);
            prev_d = d;
        end
        repeat (10) @(negedge clk);

        // ---------------- protocol invariants ------------------------------
        check("a_done_count", done_cnt[0], 3);
        check("c_done_count", done_cnt[2], 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("done_single_cycle_%0d", i), done_twice[i], 1'b0);
            check($sformatf("done_with_pin_low_%0d", i), done_low[i], 1'b0);
        end
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
